// File: rtl/nibble_serial_adder_ctrl.sv
// Runs an external 4-bit ripple adder one nibble per clock to add two W-bit operands, least significant nibble first.
// Optional macro SUB_EN adds a sub port; subtraction inverts B and seeds the carry with 1.
module nibble_serial_adder_ctrl #(
    parameter  int NIBBLES = 4,
    localparam int W       = 4 * NIBBLES
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] op_a,
    input  logic [W-1:0] op_b,
`ifdef SUB_EN
    input  logic         sub,
`endif
    output logic         busy,
    output logic         done,
    output logic [W-1:0] result,
    output logic         cout,
    output logic [3:0]   add_a,
    output logic [3:0]   add_b,
    output logic         add_cin,
    input  logic [3:0]   add_s,
    input  logic         add_cout,
    output logic [1:0]   dbg_state
);

    // Handshake: start is taken only in IDLE or DONE. busy is high for
    // exactly NIBBLES cycles, then done pulses for one cycle with result/cout valid.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int            KW     = $clog2(NIBBLES + 1);
    localparam logic [KW-1:0] K_LAST = KW'(NIBBLES - 1);

    state_t         state;
    logic [W-1:0]   sa;
    logic [W-1:0]   sb;
    logic           c;
    logic [KW-1:0]  k;
    logic           sub_r;
    logic           start_sub;
    logic           accept;
    logic [W+3:0]   res_cat;

`ifdef SUB_EN
    assign start_sub = sub;
`else
    assign start_sub = 1'b0;
`endif

    assign accept  = start && (state == IDLE || state == DONE);
    // Concatenating first keeps the MSB-side shift legal when W is only 4.
    assign res_cat = {add_s, result};

    always_comb begin
        add_a   = 4'd0;
        add_b   = 4'd0;
        add_cin = 1'b0;
        if (state == ADD) begin
            add_a   = sa[3:0];
            add_b   = sub_r ? ~sb[3:0] : sb[3:0];
            add_cin = c;
        end
    end

    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            cout   <= 1'b0;
            sa     <= '0;
            sb     <= '0;
            c      <= 1'b0;
            k      <= '0;
            sub_r  <= 1'b0;
        end else if (accept) begin
            sa    <= op_a;
            sb    <= op_b;
            sub_r <= start_sub;
            c     <= start_sub;
            k     <= '0;
            state <= ADD;
            busy  <= 1'b1;
            done  <= 1'b0;
        end else begin
            case (state)
                ADD: begin
                    result <= res_cat[W+3:4];
                    sa     <= sa >> 4;
                    sb     <= sb >> 4;
                    c      <= add_cout;
                    k      <= k + KW'(1);
                    if (k == K_LAST) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        cout  <= add_cout;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Bench for nibble_serial_adder_ctrl: models the 4-bit adder, checks results through an expected queue.
// Define SUB_EN on both bench and RTL to include the subtraction cases.
module tb_nibble_serial_adder_ctrl;

    localparam int NIBBLES = 4;
    localparam int W       = 4 * NIBBLES;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] op_a = '0;
    logic [W-1:0] op_b = '0;
    logic         sub = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         cout;
    logic [3:0]   add_a;
    logic [3:0]   add_b;
    logic         add_cin;
    logic [3:0]   add_s;
    logic         add_cout;
    logic [1:0]   dbg_state;

    int checks   = 0;
    int errors   = 0;
    int done_cnt = 0;
    int pushed   = 0;

    logic [W:0] exp_q[$];

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         s;
        logic [W-1:0] res;
        logic         co;
    } vec_t;

    vec_t vecs[6];

    nibble_serial_adder_ctrl #(.NIBBLES(NIBBLES)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .op_a      (op_a),
        .op_b      (op_b),
`ifdef SUB_EN
        .sub       (sub),
`endif
        .busy      (busy),
        .done      (done),
        .result    (result),
        .cout      (cout),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_cin   (add_cin),
        .add_s     (add_s),
        .add_cout  (add_cout),
        .dbg_state (dbg_state)
    );

    // Combinational 4-bit adder model standing in for the ripple adder.
    assign {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b} + {4'd0, add_cin};

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W:0] act, input logic [W:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: each done pulse pops one expected {cout, result}.
    always @(negedge clk) begin
        if (done) begin
            done_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done: got %h expected none", {cout, result});
            end else begin
                logic [W:0] e;
                e = exp_q.pop_front();
                if ({cout, result} !== e) begin
                    errors++;
                    $display("FAIL result: got %h expected %h", {cout, result}, e);
                end
            end
        end
    end

    task automatic push_exp(input logic [W-1:0] res, input logic co);
        exp_q.push_back({co, res});
        pushed++;
    endtask

    // Caller is 1 time unit after a rising edge with the DUT idle.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                          input logic [W-1:0] res, input logic co,
                          output logic [NIBBLES-1:0] cins);
        op_a  = a;
        op_b  = b;
        sub   = s;
        start = 1'b1;
        push_exp(res, co);
        step();
        start = 1'b0;
        for (int i = 0; i < NIBBLES; i++) begin
            check("busy_add", busy, 1);
            check("done_early", done, 0);
            cins[i] = add_cin;
            step();
        end
        check("done_cycle", done, 1);
        check("busy_in_done", busy, 0);
        step();
        check("done_pulse_len", done, 0);
        check("result_hold", {cout, result}, {co, res});
    endtask

    initial begin
        logic [NIBBLES-1:0] cins;
        logic [W-1:0]       ra, rb;
        logic [W:0]         rsum;
        int                 d0;

        vecs[0] = '{a: 16'h1234, b: 16'h4321, s: 1'b0, res: 16'h5555, co: 1'b0};
        vecs[1] = '{a: 16'hFFFF, b: 16'h0001, s: 1'b0, res: 16'h0000, co: 1'b1};
        vecs[2] = '{a: 16'h0000, b: 16'h0000, s: 1'b0, res: 16'h0000, co: 1'b0};
        vecs[3] = '{a: 16'hFFFF, b: 16'hFFFF, s: 1'b0, res: 16'hFFFE, co: 1'b1};
        vecs[4] = '{a: 16'h8000, b: 16'h8000, s: 1'b0, res: 16'h0000, co: 1'b1};
        vecs[5] = '{a: 16'h0F0F, b: 16'hF0F0, s: 1'b0, res: 16'hFFFF, co: 1'b0};

        // Reset state
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_result", result, 0);
        check("rst_cout", cout, 0);
        check("rst_add_a", add_a, 0);
        check("rst_add_b", add_b, 0);
        check("rst_add_cin", add_cin, 0);
        check("rst_state", dbg_state, 0);
        rst_n = 1'b1;
        step();

        // Table-driven vectors
        for (int i = 0; i < 6; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].res, vecs[i].co, cins);
            if (i == 1) check("carry_chain_cin", cins, 4'b1110);
            if (i == 0) check("basic_cin", cins, 4'b0000);
            check("idle_add_a", add_a, 0);
            check("idle_add_cin", add_cin, 0);
            step();
        end

        // Random operands against a reference sum
        for (int i = 0; i < 4; i++) begin
            ra   = W'($urandom_range(0, 16'hFFFF));
            rb   = W'($urandom_range(0, 16'hFFFF));
            rsum = {1'b0, ra} + {1'b0, rb};
            run_op(ra, rb, 1'b0, rsum[W-1:0], rsum[W], cins);
        end

        // start during ADD is ignored
        d0    = done_cnt;
        op_a  = 16'h1111;
        op_b  = 16'h2222;
        start = 1'b1;
        push_exp(16'h3333, 1'b0);
        step();
        start = 1'b0;
        step();
        op_a  = 16'h0F0F;
        op_b  = 16'h0101;
        start = 1'b1;
        step();
        start = 1'b0;
        check("ign_busy", busy, 1);
        step();
        check("ign_busy_last", busy, 1);
        step();
        check("ign_done", done, 1);
        repeat (8) step();
        check("ign_one_done", done_cnt - d0, 1);
        check("ign_idle", dbg_state, 0);

        // Reset in the 2nd ADD cycle aborts the operation
        op_a  = 16'h1234;
        op_b  = 16'h4321;
        start = 1'b1;
        push_exp(16'h5555, 1'b0);
        step();
        start = 1'b0;
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        void'(exp_q.pop_back());
        pushed--;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_result", result, 0);
        check("abort_cout", cout, 0);
        d0 = done_cnt;
        repeat (8) step();
        check("abort_no_done", done_cnt - d0, 0);

        // Back-to-back: new start accepted in the DONE cycle
        op_a  = 16'h1234;
        op_b  = 16'h4321;
        start = 1'b1;
        push_exp(16'h5555, 1'b0);
        step();
        start = 1'b0;
        repeat (NIBBLES) step();
        check("b2b_first_done", done, 1);
        op_a  = 16'h0001;
        op_b  = 16'h0001;
        start = 1'b1;
        push_exp(16'h0002, 1'b0);
        step();
        start = 1'b0;
        for (int i = 0; i < NIBBLES; i++) begin
            check("b2b_busy", busy, 1);
            step();
        end
        check("b2b_second_done", done, 1);
        step();
        check("b2b_result", result, 16'h0002);
        step();

`ifdef SUB_EN
        run_op(16'h5000, 16'h1234, 1'b1, 16'h3DCC, 1'b1, cins);
        step();
        run_op(16'h0001, 16'h0002, 1'b1, 16'hFFFF, 1'b0, cins);
        step();
`endif

        repeat (3) step();
        check("queue_drained", exp_q.size(), 0);
        check("done_total", done_cnt, pushed);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/nibble_serial_adder_ctrl.md
# nibble_serial_adder_ctrl

Sequencing stage wrapped around the team's 4-bit ripple-carry parallel adder. It drives the adder's operand and carry-in inputs and consumes its sum and carry-out. It adds two NIBBLES×4-bit operands one nibble per clock, least significant nibble first. A registered carry links consecutive nibbles, and the assembled result is returned with a start/busy/done handshake.

## Interface
Parameters:
- NIBBLES, default 4: operand width in nibbles; W = 4*NIBBLES; legal range 1–16.

Ports:
- Clocking and reset: one clock; reset is synchronous and active-low.
  - clk  input  1  rising-edge clock.
  - rst_n  input  1  synchronous active-low reset.
- Command side:
  - start  input  1  request; accepted only in IDLE or DONE.
  - op_a  input  W  first operand, sampled on accepted start.
  - op_b  input  W  second operand, sampled on accepted start.
  - sub  input  1  subtract request; present only with SUB_EN.
  - busy  output  1  high while in ADD.
  - done  output  1  one-cycle pulse when the result is valid.
  - result  output  W  sum; held stable from done until the next accepted start.
  - cout  output  1  final carry, or no-borrow when subtracting.
- Adder side:
  - add_a  output  4  current nibble of A.
  - add_b  output  4  current nibble of B, inverted when subtracting.
  - add_cin  output  1  carry into the current nibble.
  - add_s  input  4  adder sum.
  - add_cout  input  1  adder carry-out.

## Operation
FSM states: IDLE, ADD, DONE.
- **IDLE:** busy=0, done=0. add_a, add_b and add_cin are driven to 0.
  - start=1 → latch op_a and op_b into shift registers sa and sb.
  - Set carry register c to 0, or to 1 if subtracting.
  - Clear the nibble counter k to 0 and go to ADD.
- **ADD:** busy=1.
  - add_a = sa[3:0]; add_b = sb[3:0] (bitwise inverted when subtracting); add_cin = c.
  - Each cycle:
    - shift add_s into result from the MSB end (result >> 4, add_s into [W-1:W-4]);
    - shift sa and sb right by 4;
    - set c = add_cout and k = k+1.
  - When k == NIBBLES-1 at the clock edge, take the last step and go to DONE.
- **DONE:** lasts one cycle; done=1, busy=0, cout = c.
  - start=1 → accept exactly as in IDLE and go to ADD.
  - Otherwise go to IDLE.
- start in ADD is ignored. No queuing, and operands are not re-sampled.
- result and cout hold their values through IDLE. They are overwritten only by the next operation's shifting.
- Arithmetic is modulo 2^W; overflow is reported only through cout.
- k is ceil(log2(NIBBLES+1)) bits wide and never wraps within an operation.

## Timing
- Reset (rst_n=0 at an edge) → next cycle:
  - state IDLE; busy=0, done=0, result=0, cout=0;
  - add_a=0, add_b=0, add_cin=0; sa, sb, c and k all 0.
- Reset mid-ADD aborts the operation, with no done pulse.
- Latency: start accepted at edge 0 → busy=1 in cycles 1..NIBBLES → done=1 in cycle NIBBLES+1.
- The adder path is purely combinational within one cycle. add_s and add_cout are sampled at the same edge that advances k.
- Back-to-back: a start during the DONE cycle gives busy=1 in the following cycle. Throughput is one operation per NIBBLES+1 cycles.
- With NIBBLES=1: exactly one ADD cycle, then DONE.

## Configuration
- SUB_EN defined:
  - the sub port exists and is sampled on accepted start;
  - when sub=1: add_b = ~sb[3:0] and initial c=1, so result = A−B mod 2^W;
  - cout=1 means no borrow (A≥B).
- SUB_EN undefined:
  - no sub port; add_b = sb[3:0] and initial c=0 always.

## Test plan
NIBBLES=4 unless stated otherwise.
- Basic add: after reset, start with A=0x1234, B=0x4321 → busy high for 4 cycles, done in cycle 5, result=0x5555, cout=0.
- Carry chain: A=0xFFFF, B=0x0001 → add_cin sequence 0,1,1,1; result=0x0000, cout=1.
- Ignored start: pulse start with A=0x0F0F, B=0x0101 during ADD of 0x1111+0x2222 → result=0x3333, exactly one done pulse.
- Reset mid-op: assert rst_n=0 in the 2nd ADD cycle → next cycle busy=0, done=0, result=0, cout=0; no done pulse thereafter.
- Back-to-back: start held high across the DONE cycle with new operands 0x0001+0x0001 → second done exactly 5 cycles after the first, result=0x0002.
- SUB_EN: sub=1, A=0x5000, B=0x1234 → result=0x3DCC, cout=1. Then A=0x0001, B=0x0002 → result=0xFFFF, cout=0.
